// File: rtl/stack_round_ctrl.sv
// ---------------------------------------------------------------------------
// stack_round_ctrl
//
// Sequences one game of block stacking. The current block slides left/right
// across the playfield one UNIT per divider period. A stop press freezes it;
// the block is then trimmed to its overlap with the landed block below. No
// overlap ends the game; landing on row ROWS-1 wins it.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   start              level; begins a new game from IDLE / OVER / WIN
//   stop               level stop key; only its rising edge acts
//   curr_block_start   x of the moving block's left pixel
//   curr_block_end     x of its right pixel (start + size*UNIT - 1)
//   curr_block_size    block size in cells
//   prev_block_start   left pixel of the landed block below (0 when none)
//   prev_block_end     right pixel of the landed block below (0 when none)
//   row                current row, 0 = bottom
//   land_pulse         one-cycle strobe while a block lands
//   game_over, win     high while in OVER / WIN
//   state_dbg          raw FSM state, for debug and checker binding
//
// Optional build macro: STACK_SPEEDUP_EN
//   Defined   : move divisor shrinks every row,
//               DIV = max(MIN_DIV, MOVE_DIV - row*(MOVE_DIV>>4)).
//   Undefined : DIV = MOVE_DIV for every row.
//
// Input semantics: start and stop are plain levels sampled every clock with
// no handshake. start only acts in IDLE/OVER/WIN. stop is edge-detected
// against a one-cycle delayed copy, so a held key gives exactly one event.
// ---------------------------------------------------------------------------
module stack_round_ctrl #(
  parameter int SCREEN_W  = 320,
  parameter int UNIT      = 8,
  parameter int INIT_SIZE = 4,
  parameter int ROWS      = 12,
  parameter int MOVE_DIV  = 2000000,
  parameter int MIN_DIV   = 250000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       stop,
  output logic [8:0] curr_block_start,
  output logic [8:0] curr_block_end,
  output logic [3:0] curr_block_size,
  output logic [8:0] prev_block_start,
  output logic [8:0] prev_block_end,
  output logic [3:0] row,
  output logic       land_pulse,
  output logic       game_over,
  output logic       win,
  output logic [2:0] state_dbg
);

  // The divider counter must hold the largest divisor any build can select.
  localparam int         DIV_MAX   = (MOVE_DIV > MIN_DIV) ? MOVE_DIV : MIN_DIV;
  localparam int         DIV_W     = $clog2(DIV_MAX + 1);
  localparam logic [9:0] UNIT_W    = 10'(UNIT);
  localparam logic [8:0] UNIT_X    = 9'(UNIT);
  localparam logic [9:0] X_LAST    = 10'(SCREEN_W - 1);
  localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
  localparam logic [3:0] SIZE_INIT = 4'(INIT_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE  = 3'd1,
    S_CHECK = 3'd2,
    S_LAND  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       start_q, start_d;
  logic [3:0]       size_q, size_d;
  logic [8:0]       prev_start_q, prev_start_d;
  logic [8:0]       prev_end_q, prev_end_d;
  logic [3:0]       row_q, row_d;
  logic             dir_left_q, dir_left_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             stop_q, stop_d;

  logic [9:0]       size_px;
  logic [9:0]       curr_end_w;
  logic [9:0]       span_w;
  logic [8:0]       lo;
  logic [8:0]       hi;
  logic             stop_evt;
  logic             at_right_edge;
  logic             at_left_edge;
  logic             miss;
  logic             last_row;
  logic             div_wrap;
  logic [31:0]      div_cur;
  logic [DIV_W-1:0] div_last;

  // -------------------------------------------------------------------------
  // Move divisor selection
  // -------------------------------------------------------------------------
`ifdef STACK_SPEEDUP_EN
  logic [31:0] div_dec;

  // Follows row_q directly, so the new divisor applies from the first cycle
  // of each new row (the counter is cleared on landing anyway).
  always_comb begin
    div_dec = 32'(row_q) * 32'(MOVE_DIV >> 4);
    if (div_dec + 32'(MIN_DIV) >= 32'(MOVE_DIV)) begin
      div_cur = 32'(MIN_DIV);
    end else begin
      div_cur = 32'(MOVE_DIV) - div_dec;
    end
  end
`else
  assign div_cur = 32'(MOVE_DIV);
`endif

  assign div_last = DIV_W'(div_cur - 32'd1);

  // -------------------------------------------------------------------------
  // Shared geometry and event decode
  // -------------------------------------------------------------------------
  always_comb begin
    size_px    = 10'(size_q) * UNIT_W;
    curr_end_w = {1'b0, start_q} + size_px - 10'd1;
    stop_d     = stop;
    stop_evt   = stop & ~stop_q;
    // >= rather than == keeps the counter safe if the divisor ever shrinks
    // below the current count.
    div_wrap   = (div_q >= div_last);
    // Another step right would push the right edge past the last pixel.
    at_right_edge = (curr_end_w + UNIT_W) > X_LAST;
    at_left_edge  = (start_q == 9'd0);
    miss       = (start_q > prev_end_q) || (curr_end_w[8:0] < prev_start_q);
    lo         = (start_q > prev_start_q) ? start_q : prev_start_q;
    hi         = (curr_end_w[8:0] < prev_end_q) ? curr_end_w[8:0] : prev_end_q;
    // Both edges are UNIT-aligned, so the span divides exactly.
    span_w     = {1'b0, hi} - {1'b0, lo} + 10'd1;
    last_row   = (row_q == LAST_ROW);
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (start) state_d = S_MOVE;
      end
      S_MOVE: begin
        if (stop_evt) state_d = S_CHECK;
      end
      S_CHECK: begin
        // prev_end_q == 0 marks the floor row: nothing below to miss.
        if ((prev_end_q != 9'd0) && miss) state_d = S_OVER;
        else                              state_d = S_LAND;
      end
      S_LAND: begin
        state_d = last_row ? S_WIN : S_MOVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    start_d      = start_q;
    size_d       = size_q;
    prev_start_d = prev_start_q;
    prev_end_d   = prev_end_q;
    row_d        = row_q;
    dir_left_d   = dir_left_q;
    div_d        = div_q;

    case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (start) begin
          start_d      = 9'd0;
          size_d       = SIZE_INIT;
          prev_start_d = 9'd0;
          prev_end_d   = 9'd0;
          row_d        = 4'd0;
          dir_left_d   = 1'b0;
          div_d        = '0;
        end
      end

      S_MOVE: begin
        // A stop freezes everything, even on a divider wrap cycle.
        if (!stop_evt) begin
          if (div_wrap) begin
            div_d = '0;
            if (!dir_left_q) begin
              if (at_right_edge) begin
                dir_left_d = 1'b1;
                start_d    = start_q - UNIT_X;
              end else begin
                start_d    = start_q + UNIT_X;
              end
            end else begin
              if (at_left_edge) begin
                dir_left_d = 1'b0;
                start_d    = start_q + UNIT_X;
              end else begin
                start_d    = start_q - UNIT_X;
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end

      S_CHECK: begin
        // Trim to the overlap; an unchanged block on the floor row, and a
        // missed block is left as-is for display in OVER.
        if ((prev_end_q != 9'd0) && !miss) begin
          start_d = lo;
          size_d  = 4'(span_w / UNIT_W);
        end
      end

      S_LAND: begin
        prev_start_d = start_q;
        prev_end_d   = curr_end_w[8:0];
        // On the winning row the landed block stays on display.
        if (!last_row) begin
          row_d      = row_q + 4'd1;
          start_d    = 9'd0;
          dir_left_d = 1'b0;
          div_d      = '0;
        end
      end

      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start_q      <= 9'd0;
      size_q       <= SIZE_INIT;
      prev_start_q <= 9'd0;
      prev_end_q   <= 9'd0;
      row_q        <= 4'd0;
      dir_left_q   <= 1'b0;
      div_q        <= '0;
      stop_q       <= 1'b0;
    end else begin
      start_q      <= start_d;
      size_q       <= size_d;
      prev_start_q <= prev_start_d;
      prev_end_q   <= prev_end_d;
      row_q        <= row_d;
      dir_left_q   <= dir_left_d;
      div_q        <= div_d;
      stop_q       <= stop_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    curr_block_start = start_q;
    curr_block_end   = curr_end_w[8:0];
    curr_block_size  = size_q;
    prev_block_start = prev_start_q;
    prev_block_end   = prev_end_q;
    row              = row_q;
    land_pulse       = (state_q == S_LAND);
    game_over        = (state_q == S_OVER);
    win              = (state_q == S_WIN);
    state_dbg        = state_q;
  end

endmodule

// File: tb/tb_stack_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_round_ctrl
//
// Two instances share clk/resetn: dut_a (ROWS=12) carries the directed table,
// the corner sequences and the randomized run against the reference model;
// dut_b (ROWS=2) is used for the win sequence.
// ---------------------------------------------------------------------------
module tb_stack_round_ctrl;

  localparam int SW     = 64;
  localparam int U      = 8;
  localparam int INIT   = 4;
  localparam int DIV    = 4;
  localparam int ROWS_A = 12;
  localparam int ROWS_B = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic       start_a, stop_a;
  logic [8:0] cs_a, ce_a, ps_a, pe_a;
  logic [3:0] sz_a, row_a;
  logic       land_a, over_a, win_a;
  logic [2:0] dbg_a;

  logic       start_b, stop_b;
  logic [8:0] cs_b, ce_b, ps_b, pe_b;
  logic [3:0] sz_b, row_b;
  logic       land_b, over_b, win_b;
  logic [2:0] dbg_b;

  stack_round_ctrl #(
    .SCREEN_W(SW), .UNIT(U), .INIT_SIZE(INIT), .ROWS(ROWS_A),
    .MOVE_DIV(DIV), .MIN_DIV(1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .stop(stop_a),
    .curr_block_start(cs_a), .curr_block_end(ce_a), .curr_block_size(sz_a),
    .prev_block_start(ps_a), .prev_block_end(pe_a), .row(row_a),
    .land_pulse(land_a), .game_over(over_a), .win(win_a), .state_dbg(dbg_a)
  );

  stack_round_ctrl #(
    .SCREEN_W(SW), .UNIT(U), .INIT_SIZE(INIT), .ROWS(ROWS_B),
    .MOVE_DIV(DIV), .MIN_DIV(1)
  ) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .stop(stop_b),
    .curr_block_start(cs_b), .curr_block_end(ce_b), .curr_block_size(sz_b),
    .prev_block_start(ps_b), .prev_block_end(pe_b), .row(row_b),
    .land_pulse(land_b), .game_over(over_b), .win(win_b), .state_dbg(dbg_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (dut_a) ----------------
  // Game-level view: while moving, the block position is a triangle wave of
  // the number of whole divider periods spent in the current row.
  localparam int P_IDLE = 0, P_MOVE = 1, P_CHECK = 2, P_LAND = 3, P_OVER = 4, P_WIN = 5;
  int m_phase, m_mcyc, m_fix, m_size, m_ps, m_pe, m_row;
  bit m_stop_prev;

  function automatic int tri_x(input int steps, input int size);
    int m, k;
    m = (SW - size * U) / U;
    k = steps % (2 * m);
    return ((k <= m) ? k : (2 * m - k)) * U;
  endfunction

  function automatic int m_cs();
    return (m_phase == P_MOVE) ? tri_x(m_mcyc / DIV, m_size) : m_fix;
  endfunction

  task automatic model_update(input bit rst, input bit st, input bit sp);
    bit ev;
    int ce, lo, hi;
    if (!rst) begin
      m_phase = P_IDLE; m_fix = 0; m_size = INIT; m_ps = 0; m_pe = 0;
      m_row = 0; m_mcyc = 0; m_stop_prev = 0;
      return;
    end
    ev = sp && !m_stop_prev;
    m_stop_prev = sp;
    case (m_phase)
      P_IDLE, P_OVER, P_WIN: begin
        if (st) begin
          m_phase = P_MOVE; m_row = 0; m_size = INIT; m_mcyc = 0;
          m_ps = 0; m_pe = 0; m_fix = 0;
        end
      end
      P_MOVE: begin
        if (ev) begin
          m_fix = m_cs();
          m_phase = P_CHECK;
        end else begin
          m_mcyc++;
        end
      end
      P_CHECK: begin
        ce = m_fix + m_size * U - 1;
        if (m_pe == 0) begin
          m_phase = P_LAND;
        end else if (m_fix > m_pe || ce < m_ps) begin
          m_phase = P_OVER;
        end else begin
          lo = (m_fix > m_ps) ? m_fix : m_ps;
          hi = (ce < m_pe) ? ce : m_pe;
          m_fix = lo;
          m_size = (hi - lo + 1) / U;
          m_phase = P_LAND;
        end
      end
      P_LAND: begin
        m_ps = m_fix;
        m_pe = m_fix + m_size * U - 1;
        if (m_row == ROWS_A - 1) begin
          m_phase = P_WIN;
        end else begin
          m_row++; m_mcyc = 0; m_phase = P_MOVE;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; applies inputs, lets one rising edge pass, returns
  // at the following negedge so outputs are sampled mid-cycle.
  task automatic step(input bit rst, input bit st, input bit sp);
    resetn  = rst;
    start_a = st;
    stop_a  = sp;
    @(posedge clk);
    model_update(rst, st, sp);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; bit st; bit sp; int cyc;
    int cs; int ce; int sz; int ps; int pe; int row;
    bit land; bit over; bit win;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst, input bit st, input bit sp, input int cyc,
                     input int cs, input int ce, input int sz, input int ps,
                     input int pe, input int row, input bit land, input bit over,
                     input bit win);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.cyc = cyc;
    v.cs = cs; v.ce = ce; v.sz = sz; v.ps = ps; v.pe = pe; v.row = row;
    v.land = land; v.over = over; v.win = win;
    tbl.push_back(v);
  endtask

  initial begin
    int lands;
    bit sp_r, st_r, rst_r;
    logic [21:0] a_blk, e_blk;
    logic [24:0] a_misc, e_misc;

    resetn = 1'b0; start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    @(negedge clk);

    //   rst st sp cyc | cs  ce sz  ps  pe row land over win
    add(0, 0, 0, 2,    0, 31, 4,  0,  0, 0, 0, 0, 0); // reset values
    add(1, 1, 0, 1,    0, 31, 4,  0,  0, 0, 0, 0, 0); // start -> MOVE
    add(1, 0, 0, 3,    0, 31, 4,  0,  0, 0, 0, 0, 0); // divider not yet wrapped
    add(1, 0, 0, 1,    8, 39, 4,  0,  0, 0, 0, 0, 0); // first step after 4 cycles
    add(1, 0, 0, 12,  32, 63, 4,  0,  0, 0, 0, 0, 0); // reaches right edge
    add(1, 0, 0, 4,   24, 55, 4,  0,  0, 0, 0, 0, 0); // bounce left
    add(1, 0, 0, 12,   0, 31, 4,  0,  0, 0, 0, 0, 0); // back to 0
    add(1, 0, 0, 4,    8, 39, 4,  0,  0, 0, 0, 0, 0); // bounce right
    add(1, 0, 0, 4,   16, 47, 4,  0,  0, 0, 0, 0, 0);
    add(1, 0, 1, 1,   16, 47, 4,  0,  0, 0, 0, 0, 0); // stop -> CHECK, frozen
    add(1, 0, 1, 1,   16, 47, 4,  0,  0, 0, 1, 0, 0); // LAND pulse
    add(1, 0, 1, 1,    0, 31, 4, 16, 47, 1, 0, 0, 0); // row 1, prev set
    add(1, 0, 0, 16,  32, 63, 4, 16, 47, 1, 0, 0, 0); // held stop gave no event
    add(1, 0, 1, 1,   32, 63, 4, 16, 47, 1, 0, 0, 0); // CHECK
    add(1, 0, 1, 1,   32, 47, 2, 16, 47, 1, 1, 0, 0); // trimmed, LAND
    add(1, 0, 1, 1,    0, 15, 2, 32, 47, 2, 0, 0, 0); // row 2
    add(1, 0, 0, 1,    0, 15, 2, 32, 47, 2, 0, 0, 0);
    add(1, 0, 1, 1,    0, 15, 2, 32, 47, 2, 0, 0, 0); // CHECK
    add(1, 0, 1, 1,    0, 15, 2, 32, 47, 2, 0, 1, 0); // miss -> OVER
    add(1, 0, 0, 5,    0, 15, 2, 32, 47, 2, 0, 1, 0); // frozen
    add(1, 1, 0, 1,    0, 31, 4,  0,  0, 0, 0, 0, 0); // restart
    add(1, 1, 0, 4,    8, 39, 4,  0,  0, 0, 0, 0, 0); // start ignored in MOVE

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].rst, tbl[i].st, tbl[i].sp);
      chk($sformatf("v%0d_cs", i),   cs_a,   tbl[i].cs);
      chk($sformatf("v%0d_ce", i),   ce_a,   tbl[i].ce);
      chk($sformatf("v%0d_sz", i),   sz_a,   tbl[i].sz);
      chk($sformatf("v%0d_ps", i),   ps_a,   tbl[i].ps);
      chk($sformatf("v%0d_pe", i),   pe_a,   tbl[i].pe);
      chk($sformatf("v%0d_row", i),  row_a,  tbl[i].row);
      chk($sformatf("v%0d_land", i), land_a, tbl[i].land);
      chk($sformatf("v%0d_over", i), over_a, tbl[i].over);
      chk($sformatf("v%0d_win", i),  win_a,  tbl[i].win);
    end

    // ---- stop coinciding with a divider wrap: no step ----
    step(0, 0, 0);
    step(1, 1, 0);
    repeat (3) step(1, 0, 0);
    step(1, 0, 1);
    chk("wrap_stop_cs", cs_a, 0);
    step(1, 0, 1);
    chk("wrap_stop_land", land_a, 1);
    step(1, 0, 1);
    chk("wrap_stop_pe", pe_a, 31);
    chk("wrap_stop_row", row_a, 1);

    // ---- held stop: exactly one landing ----
    step(1, 0, 0);
    step(1, 0, 0);
    lands = 0;
    for (int c = 0; c < 100; c++) begin
      step(1, 0, 1);
      if (land_a) lands++;
    end
    chk("held_lands", lands, 1);
    chk("held_row", row_a, 2);
    chk("held_over", over_a, 0);

    // ---- reset while in CHECK ----
    step(1, 0, 0);
    step(1, 0, 1);
    chk("rchk_land", land_a, 0);
    step(0, 0, 1);
    chk("rchk_cs", cs_a, 0);
    chk("rchk_sz", sz_a, INIT);
    chk("rchk_ps", ps_a, 0);
    chk("rchk_pe", pe_a, 0);
    chk("rchk_row", row_a, 0);
    chk("rchk_land2", land_a, 0);
    lands = 0;
    for (int c = 0; c < 3; c++) begin
      step(1, 0, 0);
      if (land_a) lands++;
    end
    chk("rchk_idle_land", lands, 0);
    chk("rchk_idle_cs", cs_a, 0);

    // ---- win on dut_b (ROWS=2) ----
    lands = 0;
    start_b = 1; step(1, 0, 0);
    start_b = 0; stop_b = 1; step(1, 0, 0);
    if (land_b) lands++;
    step(1, 0, 0);
    if (land_b) lands++;
    stop_b = 0; step(1, 0, 0);
    chk("win_early", win_b, 0);
    chk("win_row1", row_b, 1);
    step(1, 0, 0);
    stop_b = 1; step(1, 0, 0);
    if (land_b) lands++;
    step(1, 0, 0);
    if (land_b) lands++;
    step(1, 0, 0);
    chk("win_flag", win_b, 1);
    chk("win_lands", lands, 2);
    chk("win_row", row_b, 1);
    chk("win_pe", pe_b, 31);
    chk("win_over", over_b, 0);
    stop_b = 0;
    repeat (3) step(1, 0, 0);
    chk("win_held", win_b, 1);
    chk("win_frozen_cs", cs_b, 0);
    start_b = 1; step(1, 0, 0);
    start_b = 0;
    chk("win_restart_win", win_b, 0);
    chk("win_restart_pe", pe_b, 0);
    chk("win_restart_row", row_b, 0);

    // ---- randomized run against the model ----
    step(0, 0, 0);
    sp_r = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_r = ($urandom_range(0, 499) != 0);
      st_r  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) sp_r = ~sp_r;
      step(rst_r, st_r, sp_r);
      a_blk  = {cs_a, ce_a, sz_a};
      e_blk  = {9'(m_cs()), 9'(m_cs() + m_size * U - 1), 4'(m_size)};
      a_misc = {ps_a, pe_a, row_a, land_a, over_a, win_a};
      e_misc = {9'(m_ps), 9'(m_pe), 4'(m_row), m_phase == P_LAND,
                m_phase == P_OVER, m_phase == P_WIN};
      chk($sformatf("rnd%0d_blk", c), a_blk, e_blk);
      chk($sformatf("rnd%0d_misc", c), a_misc, e_misc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
